alu_exec_unit: RTL and testbench

Integer execution unit directly downstream of the reservation station. Each cycle it is idle, it accepts one ready instruction (op, two resolved operands, ROB tag), computes the result, and holds it on the common data bus (CDB) request lines until granted. While occupied it asserts `busy` back to the reservation station, which suppresses issue.

---
 rtl/alu_exec_unit_pkg.sv | 17 +
 rtl/alu_exec_unit_comb.sv | 34 +++
 rtl/alu_exec_unit.sv | 102 ++++++++++
 tb/tb_alu_exec_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared widths and opcode encodings for the integer execution unit
package alu_exec_unit_pkg;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W = 6;
  localparam int ALU_TAG_W = 4;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 6'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 6'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 6'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 6'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 6'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 6'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 6'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 6'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 6'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 6'd9;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 6'd10;
endpackage

// File: rtl/alu_exec_unit_comb.sv
// alu_comb: single-cycle combinational result; unknown opcodes (and MUL) yield zero
module alu_comb
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W = ALU_OP_W
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);
  localparam int SH_W = $clog2(DATA_W);
  logic [SH_W-1:0] sh;
  logic signed [DATA_W-1:0] sra;
  logic slt, sltu;
  assign sh = b_i[SH_W-1:0];
  // Kept in its own signal so the arithmetic shift is evaluated in signed context
  assign sra = $signed(a_i) >>> sh;
  assign slt = $signed(a_i) < $signed(b_i);
  assign sltu = a_i < b_i;
  always_comb begin
    res_o = op_i == ALU_ADD  ? a_i + b_i :
            op_i == ALU_SUB  ? a_i - b_i :
            op_i == ALU_AND  ? a_i & b_i :
            op_i == ALU_OR   ? a_i | b_i :
            op_i == ALU_XOR  ? a_i ^ b_i :
            op_i == ALU_SLL  ? a_i << sh :
            op_i == ALU_SRL  ? a_i >> sh :
            op_i == ALU_SRA  ? sra :
            op_i == ALU_SLT  ? {{(DATA_W-1){1'b0}}, slt} :
            op_i == ALU_SLTU ? {{(DATA_W-1){1'b0}}, sltu} : '0;
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: issue/execute/CDB-hold FSM; define ALU_MUL_EN for the iterative shift-add MUL
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W = ALU_OP_W,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [TAG_W-1:0]  target,
  output logic              busy,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_val
);
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, CALC, WAIT_BUS} state_e;
  localparam int CNT_W = $clog2(DATA_W);
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic is_mul;
  assign is_mul = op == ALU_MUL;
`else
  typedef enum logic [1:0] {IDLE, WAIT_BUS} state_e;
`endif
  state_e state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d, comb_res;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic accept;
  alu_comb #(.DATA_W(DATA_W), .OP_W(OP_W)) u_comb (
    .op_i(op), .a_i(val1), .b_i(val2), .res_o(comb_res)
  );
  assign accept = state_q == IDLE && issue_valid && !flush;
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    tag_d = tag_q;
`ifdef ALU_MUL_EN
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
`endif
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      tag_d = target;
`ifdef ALU_MUL_EN
      mcand_d = val1;
      mplier_d = val2;
      cnt_d = '0;
      state_d = is_mul ? CALC : WAIT_BUS;
      res_d = is_mul ? '0 : comb_res;
`else
      state_d = WAIT_BUS;
      res_d = comb_res;
`endif
`ifdef ALU_MUL_EN
    end else if (state_q == CALC) begin
      // res_q doubles as the product accumulator until the last step
      res_d = mplier_q[0] ? res_q + mcand_q : res_q;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CNT_W'(DATA_W - 1) ? WAIT_BUS : CALC;
`endif
    end else if (state_q == WAIT_BUS && cdb_grant) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q <= '0;
      tag_q <= '0;
`ifdef ALU_MUL_EN
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      tag_q <= tag_d;
`ifdef ALU_MUL_EN
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
`endif
    end
  end
  assign busy = state_q != IDLE;
  assign cdb_req = state_q == WAIT_BUS;
  assign cdb_tag = tag_q;
  assign cdb_val = res_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks against an arithmetic reference model
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, flush, issue_valid, cdb_grant;
  logic [5:0] op;
  logic [31:0] val1, val2;
  logic [3:0] target;
  logic busy, cdb_req;
  logic [3:0] cdb_tag;
  logic [31:0] cdb_val;
  int total = 0;
  int bad = 0;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .op(op),
    .val1(val1), .val2(val2), .target(target), .busy(busy), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_val(cdb_val)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    int unsigned sh;
    longint unsigned p;
    sa = a;
    sb = b;
    sh = b % 32;
    p = longint'(a) * longint'(b);
    if (o == ALU_ADD) return a + b;
    if (o == ALU_SUB) return a - b;
    if (o == ALU_AND) return a & b;
    if (o == ALU_OR) return a | b;
    if (o == ALU_XOR) return a ^ b;
    if (o == ALU_SLL) return a << sh;
    if (o == ALU_SRL) return a >> sh;
    if (o == ALU_SRA) return 32'(sa >>> sh);
    if (o == ALU_SLT) return (sa < sb) ? 32'd1 : 32'd0;
    if (o == ALU_SLTU) return (a < b) ? 32'd1 : 32'd0;
    if (o == ALU_MUL && MUL_EN) return p[31:0];
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] t, input int gd);
    logic [31:0] e;
    int n;
    e = model(o, a, b);
    op = o; val1 = a; val2 = b; target = t; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    n = 0;
    while (!cdb_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), (MUL_EN && o == ALU_MUL) ? 64'd32 : 64'd0);
    chk("val", 64'(cdb_val), 64'(e));
    chk("tag", 64'(cdb_tag), 64'(t));
    chk("busy", 64'(busy), 64'd1);
    repeat (gd) begin
      @(negedge clk);
      chk("hold", {27'd0, cdb_req, cdb_tag, cdb_val}, {27'd0, 1'b1, t, e});
    end
    cdb_grant = 1'b1;
    @(negedge clk);
    cdb_grant = 1'b0;
    chk("release", {62'd0, cdb_req, busy}, 64'd0);
  endtask

  initial begin
    int hits;
    logic [5:0] ro;
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; cdb_grant = 1'b0;
    op = '0; val1 = '0; val2 = '0; target = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset", {27'd0, busy, cdb_req, cdb_tag, cdb_val}, 64'd0);
    @(negedge clk);
    run(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'd3, 0);
    chk("add_ovf", 64'(cdb_val), 64'h8000_0000);
    // SRA held without grant while a second issue is attempted
    op = ALU_SRA; val1 = 32'h8000_0000; val2 = 32'd4; target = 4'd5; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("sra_hold", {27'd0, cdb_req, cdb_tag, cdb_val}, {27'd0, 1'b1, 4'd5, 32'hF800_0000});
      issue_valid = (i == 2);
      op = ALU_ADD; val1 = 32'd1; val2 = 32'd1; target = 4'd9;
      @(negedge clk);
    end
    issue_valid = 1'b0;
    chk("sra_still", {27'd0, cdb_req, cdb_tag, cdb_val}, {27'd0, 1'b1, 4'd5, 32'hF800_0000});
    cdb_grant = 1'b1;
    @(negedge clk);
    cdb_grant = 1'b0;
    @(negedge clk);
    chk("ignored_issue", {62'd0, cdb_req, busy}, 64'd0);
    run(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd1, 1);
    run(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd2, 0);
    run(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 4'd4, 2);
    // flush in WAIT_BUS without grant
    op = ALU_OR; val1 = 32'hF0; val2 = 32'h0F; target = 4'd7; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    chk("pre_flush_req", 64'(cdb_req), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_wait", {62'd0, cdb_req, busy}, 64'd0);
    // flush with a same-cycle issue drops the issue
    flush = 1'b1; issue_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0;
    chk("flush_issue", {62'd0, cdb_req, busy}, 64'd0);
    run(ALU_ADD, 32'd100, 32'd23, 4'd8, 0);
    chk("post_flush_add", 64'(cdb_val), 64'd123);
    // flush together with grant finishes the broadcast and idles
    op = ALU_XOR; val1 = 32'hFF; val2 = 32'h0F; target = 4'd6; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0; flush = 1'b1; cdb_grant = 1'b1;
    @(negedge clk);
    flush = 1'b0; cdb_grant = 1'b0;
    chk("flush_grant", {62'd0, cdb_req, busy}, 64'd0);
    run(ALU_MUL, 32'd12345, 32'd6789, 4'd10, 1);
    chk("mul_val", 64'(cdb_val), MUL_EN ? 64'd83810205 : 64'd0);
    // flush partway through a MUL must suppress its broadcast
    op = ALU_MUL; val1 = 32'd3; val2 = 32'd5; target = 4'd11; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    if (!cdb_req) repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    hits = 0;
    repeat (40) begin
      hits += int'(cdb_req) + int'(busy);
      @(negedge clk);
    end
    chk("mul_flush", 64'(hits), 64'd0);
    for (int k = 0; k < 40; k++) begin
      ro = 6'($urandom_range(0, 11));
      if (ro == 6'd11) ro = 6'h3F;
      if (ro == ALU_MUL && k % 4 != 0) ro = ALU_SUB;
      run(ro, $urandom, (k % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom,
          4'($urandom), int'($urandom_range(0, 3)));
    end
    // reset while waiting for the bus
    op = ALU_SUB; val1 = 32'd9; val2 = 32'd4; target = 4'd12; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
    chk("pre_rst_req", 64'(cdb_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait", {27'd0, busy, cdb_req, cdb_tag, cdb_val}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
